// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch: IDLE/RUN/PAUSE control, prescaler, ripple digits.
// Define BCD_STOPWATCH_SAT_EN to saturate at 9999 and pause instead of wrapping.
module bcd_stopwatch_ctrl #(
  parameter int TICK_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [PW-1:0] presc_q;
  logic adv, step, at_max;
  logic c0, c1, c2, c3;
  logic [3:0] n0, n1, n2, n3;

  // stop/clear on the due edge freeze the prescaler and kill the step
  assign adv     = (state_q == RUN) && !stop && !clear;
  assign step    = adv && (presc_q == PMAX);
  assign running = (state_q == RUN);

  assign c0 = (d0 == 4'd9);
  assign c1 = (d1 == 4'd9);
  assign c2 = (d2 == 4'd9);
  assign c3 = (d3 == 4'd9);
  assign at_max = c0 && c1 && c2 && c3;

  always_comb begin
    n0 = c0 ? 4'd0 : d0 + 4'd1;
    n1 = d1;
    n2 = d2;
    n3 = d3;
    if (c0)
      n1 = c1 ? 4'd0 : d1 + 4'd1;
    if (c0 && c1)
      n2 = c2 ? 4'd0 : d2 + 4'd1;
    if (c0 && c1 && c2)
      n3 = c3 ? 4'd0 : d3 + 4'd1;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN)
        state_d = PAUSE;
    end else if (start) begin
      if (state_q != RUN)
        state_d = RUN;
    end else begin
`ifdef BCD_STOPWATCH_SAT_EN
      if (step && at_max)
        state_d = PAUSE;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      d0      <= 4'd0;
      d1      <= 4'd0;
      d2      <= 4'd0;
      d3      <= 4'd0;
      ovf     <= 1'b0;
    end else if (clear) begin
      presc_q <= '0;
      d0      <= 4'd0;
      d1      <= 4'd0;
      d2      <= 4'd0;
      d3      <= 4'd0;
      ovf     <= 1'b0;
    end else begin
      ovf <= step && at_max;
      if (adv)
        presc_q <= (presc_q == PMAX) ? '0 : presc_q + PW'(1);
`ifdef BCD_STOPWATCH_SAT_EN
      if (step && !at_max) begin
`else
      if (step) begin
`endif
        d0 <= n0;
        d1 <= n1;
        d2 <= n2;
        d3 <= n3;
      end
    end
  end

endmodule
